// File: rtl/axis_stall_detector.sv
// axis_stall_detector: watches NUM_CH AXI-Stream valid/ready taps and flags
// any channel whose TVALID stays high without TREADY for threshold cycles.
// Each channel runs IDLE -> STALL -> BLOCKED with a saturating stall counter.
// The first channel to block since reset/clear is captured for debug.
//
// The monitored taps follow AXI-Stream valid/ready rules: a beat transfers
// when tvalid and tready are both 1 on a rising edge. A cycle with tvalid=1
// and tready=0 is a stall cycle. Every other combination is a non-stall cycle.
module axis_stall_detector #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] axis_tvalid,
  input  logic [NUM_CH-1:0] axis_tready,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              sticky_en,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [3:0]        first_ch,
  output logic              first_vld
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];

  logic [NUM_CH-1:0]  stall;
  logic [NUM_CH-1:0]  enter_blk;
  logic [NUM_CH-1:0]  block_d;
  logic [NUM_CH-1:0]  block_q;
  logic               any_d;
  logic               any_q;
  logic [3:0]         first_ch_d;
  logic [3:0]         first_ch_q;
  logic               first_vld_d;
  logic               first_vld_q;
  logic [CNT_W-1:0]   t_eff;

  assign stall = axis_tvalid & ~axis_tready;

  // A threshold of 0 behaves as 1 so a single stall cycle still blocks.
  always_comb begin
    t_eff = (threshold == '0) ? CNT_W'(1) : threshold;
  end

  // Per-channel next-state and saturating counter; clear overrides the bus.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            cnt_d[i] = '0;
            if (stall[i]) begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = (t_eff == CNT_W'(1)) ? ST_BLOCKED : ST_STALL;
            end
          end
          ST_STALL: begin
            if (stall[i]) begin
              cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
              // Widened compare so a saturated counter cannot wrap past T_eff.
              if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, t_eff}) begin
                state_d[i] = ST_BLOCKED;
              end
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end
          ST_BLOCKED: begin
            if (!sticky_en && !stall[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (stall[i]) begin
              cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Block flags are a decode of the next state so they register on the
  // same edge the FSM enters BLOCKED.
  always_comb begin
    block_d   = '0;
    enter_blk = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      block_d[i]   = (state_d[i] == ST_BLOCKED);
      enter_blk[i] = block_d[i] && (state_q[i] != ST_BLOCKED);
    end
    any_d = |block_d;
  end

  // Capture the lowest-index channel entering BLOCKED while no capture is held.
  always_comb begin
    first_ch_d  = first_ch_q;
    first_vld_d = first_vld_q;
    if (clear) begin
      first_ch_d  = '0;
      first_vld_d = 1'b0;
    end else if (!first_vld_q) begin
      // Descending scan so the lowest entering index wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (enter_blk[i]) begin
          first_ch_d  = 4'(i);
          first_vld_d = 1'b1;
        end
      end
    end
  end

  // State, counters and registered outputs; reset wins over clear.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      block_q     <= '0;
      any_q       <= 1'b0;
      first_ch_q  <= '0;
      first_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      block_q     <= block_d;
      any_q       <= any_d;
      first_ch_q  <= first_ch_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign axis_block_sigs = block_q;
  assign any_block       = any_q;
  assign first_ch        = first_ch_q;
  assign first_vld       = first_vld_q;

endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed bench for axis_stall_detector (NUM_CH=2, CNT_W=16).
// Each vector drives one cycle of inputs; its expected outputs are the
// register values after the rising edge that samples those inputs.
module tb_axis_stall_detector;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic              ap_clk;
  logic              ap_rst_n;
  logic [NUM_CH-1:0] axis_tvalid;
  logic [NUM_CH-1:0] axis_tready;
  logic [CNT_W-1:0]  threshold;
  logic              sticky_en;
  logic              clear;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic [3:0]        first_ch;
  logic              first_vld;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        stk;
    logic [15:0] thr;
    logic [1:0]  tv;
    logic [1:0]  tr;
    logic [1:0]  e_blk;
    logic        e_any;
    logic [3:0]  e_fch;
    logic        e_fvl;
    string       name;
  } vec_t;

  vec_t vq[$];

  // clock / reset block
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  axis_stall_detector #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .axis_tvalid     (axis_tvalid),
    .axis_tready     (axis_tready),
    .threshold       (threshold),
    .sticky_en       (sticky_en),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .first_ch        (first_ch),
    .first_vld       (first_vld)
  );

  // scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of inputs, then compare registered outputs
  task automatic cyc(input vec_t v);
    ap_rst_n    = v.rst_n;
    clear       = v.clr;
    sticky_en   = v.stk;
    threshold   = v.thr;
    axis_tvalid = v.tv;
    axis_tready = v.tr;
    @(posedge ap_clk);
    #1;
    chk({v.name, ".blk"}, 8'(axis_block_sigs), 8'(v.e_blk));
    chk({v.name, ".any"}, 8'(any_block),       8'(v.e_any));
    chk({v.name, ".fch"}, 8'(first_ch),        8'(v.e_fch));
    chk({v.name, ".fvl"}, 8'(first_vld),       8'(v.e_fvl));
  endtask

  function automatic vec_t mk(input logic rst_n, input logic clr, input logic stk,
                              input logic [15:0] thr, input logic [1:0] tv,
                              input logic [1:0] tr, input logic [1:0] e_blk,
                              input logic e_any, input logic [3:0] e_fch,
                              input logic e_fvl, input string name);
    vec_t v;
    v.rst_n = rst_n; v.clr = clr; v.stk = stk; v.thr = thr;
    v.tv = tv; v.tr = tr; v.e_blk = e_blk; v.e_any = e_any;
    v.e_fch = e_fch; v.e_fvl = e_fvl; v.name = name;
    return v;
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    ap_rst_n    = 1'b0;
    clear       = 1'b0;
    sticky_en   = 1'b0;
    threshold   = '0;
    axis_tvalid = '0;
    axis_tready = '0;

    //            rst clr stk thr  tv     tr     blk    any  fch  fvl
    vq.push_back(mk(0, 0, 0, 4, 2'b00, 2'b00, 2'b00, 0, 0, 0, "rst0"));
    vq.push_back(mk(0, 1, 0, 4, 2'b11, 2'b00, 2'b00, 0, 0, 0, "rst_over_clr"));
    // threshold 4, ch0 stalls 6 cycles then handshakes
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b00, 0, 0, 0, "t4_c0"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b00, 0, 0, 0, "t4_c1"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b00, 0, 0, 0, "t4_c2"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b01, 1, 0, 1, "t4_c3"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b01, 1, 0, 1, "t4_c4"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b00, 2'b01, 1, 0, 1, "t4_c5"));
    vq.push_back(mk(1, 0, 0, 4, 2'b01, 2'b01, 2'b00, 0, 0, 1, "t4_c6"));
    // clear beats a concurrent stall
    vq.push_back(mk(1, 1, 0, 4, 2'b01, 2'b00, 2'b00, 0, 0, 0, "clr_stall"));
    vq.push_back(mk(1, 0, 0, 4, 2'b00, 2'b11, 2'b00, 0, 0, 0, "idle_a"));
    // ch1: 3 stalls, handshake, 3 stalls -> never blocks
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s0"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s1"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s2"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b10, 2'b00, 0, 0, 0, "brk_hs"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s3"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s4"));
    vq.push_back(mk(1, 0, 0, 4, 2'b10, 2'b00, 2'b00, 0, 0, 0, "brk_s5"));
    vq.push_back(mk(1, 0, 0, 4, 2'b00, 2'b10, 2'b00, 0, 0, 0, "brk_end"));
    // threshold 0 acts as 1: single stall on ch1 blocks for one cycle
    vq.push_back(mk(1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 1, 1, 1, "t0_stall"));
    vq.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, "t0_rel"));
    // later block on ch0 must not overwrite first_ch
    vq.push_back(mk(1, 0, 0, 0, 2'b01, 2'b00, 2'b01, 1, 1, 1, "first_hold"));
    vq.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, "first_rel"));
    vq.push_back(mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, "clr_b"));
    // threshold lowered mid-stall: cnt=3 already >= 2, next stall blocks
    vq.push_back(mk(1, 0, 0, 5, 2'b01, 2'b00, 2'b00, 0, 0, 0, "thr_s0"));
    vq.push_back(mk(1, 0, 0, 5, 2'b01, 2'b00, 2'b00, 0, 0, 0, "thr_s1"));
    vq.push_back(mk(1, 0, 0, 5, 2'b01, 2'b00, 2'b00, 0, 0, 0, "thr_s2"));
    vq.push_back(mk(1, 0, 0, 2, 2'b01, 2'b00, 2'b01, 1, 0, 1, "thr_drop"));
    vq.push_back(mk(1, 0, 0, 2, 2'b00, 2'b00, 2'b00, 0, 0, 1, "thr_rel"));
    vq.push_back(mk(1, 1, 0, 2, 2'b00, 2'b00, 2'b00, 0, 0, 0, "clr_c"));
    // reset mid-stall discards progress; block rises at cycle 6
    vq.push_back(mk(1, 0, 0, 3, 2'b01, 2'b00, 2'b00, 0, 0, 0, "rs_c0"));
    vq.push_back(mk(1, 0, 0, 3, 2'b01, 2'b00, 2'b00, 0, 0, 0, "rs_c1"));
    vq.push_back(mk(0, 0, 0, 3, 2'b01, 2'b00, 2'b00, 0, 0, 0, "rs_c2"));
    vq.push_back(mk(1, 0, 0, 3, 2'b01, 2'b00, 2'b00, 0, 0, 0, "rs_c3"));
    vq.push_back(mk(1, 0, 0, 3, 2'b01, 2'b00, 2'b00, 0, 0, 0, "rs_c4"));
    vq.push_back(mk(1, 0, 0, 3, 2'b01, 2'b00, 2'b01, 1, 0, 1, "rs_c5"));
    vq.push_back(mk(1, 0, 0, 3, 2'b00, 2'b00, 2'b00, 0, 0, 1, "rs_rel"));
    vq.push_back(mk(1, 1, 0, 3, 2'b00, 2'b00, 2'b00, 0, 0, 0, "clr_d"));

    foreach (vq[i]) cyc(vq[i]);

    // sticky hold: both channels block together, stall removed, held until clear
    cyc(mk(1, 0, 0, 2, 2'b11, 2'b00, 2'b00, 0, 0, 0, "stk_c0"));
    cyc(mk(1, 0, 0, 2, 2'b11, 2'b00, 2'b11, 1, 0, 1, "stk_c1"));
    for (int c = 2; c < 20; c++) begin
      logic [1:0] tv;
      logic [1:0] tr;
      tv = 2'(c);
      tr = 2'(c >> 1);
      cyc(mk(1, 0, 1, 2, tv, tr, 2'b11, 1, 0, 1, $sformatf("stk_hold%0d", c)));
    end
    cyc(mk(1, 1, 1, 2, 2'b11, 2'b00, 2'b00, 0, 0, 0, "stk_clr"));
    cyc(mk(1, 0, 0, 2, 2'b00, 2'b00, 2'b00, 0, 0, 0, "stk_after"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_stall_detector.md
AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored AXI-Stream channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: width of the per-channel stall counter and of threshold.
REQ-003 Port ap_clk, input, 1 bit: the single clock; all logic is rising-edge synchronous to it.
REQ-004 Port ap_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port axis_tvalid, input, NUM_CH bits: per-channel TVALID tap, bit i = channel i.
REQ-006 Port axis_tready, input, NUM_CH bits: per-channel TREADY tap, bit i = channel i.
REQ-007 Port threshold, input, CNT_W bits: number of consecutive stall cycles that declares a block; sampled every cycle.
REQ-008 Port sticky_en, input, 1 bit: 1 = blocked state is held until clear; 0 = blocked state releases when the stall ends.
REQ-009 Port clear, input, 1 bit: single-cycle pulse that returns all channels to IDLE and clears the first-block capture.
REQ-010 Port axis_block_sigs, output, NUM_CH bits: registered per-channel block flag, intended to drive a deadlock monitor's axis_block_sigs input.
REQ-011 Port any_block, output, 1 bit: registered OR of all channel states equal to BLOCKED.
REQ-012 Port first_ch, output, 4 bits: index of the first channel to enter BLOCKED since reset or clear.
REQ-013 Port first_vld, output, 1 bit: first_ch holds a valid capture.

Function
REQ-014 Stall cycle: channel i has a stall cycle when axis_tvalid[i]=1 and axis_tready[i]=0; every other combination is a non-stall cycle.
REQ-015 Each channel runs an independent FSM with states IDLE, STALL and BLOCKED, plus a counter cnt[i] of CNT_W bits.
REQ-016 Effective threshold: T_eff = 1 when threshold = 0; otherwise T_eff = threshold.
REQ-017 IDLE: cnt is held at 0; a stall cycle sets cnt to 1 and moves to STALL, or moves directly to BLOCKED when T_eff = 1.
REQ-018 STALL: a stall cycle increments cnt and moves to BLOCKED when cnt+1 >= T_eff; a non-stall cycle moves to IDLE and sets cnt to 0.
REQ-019 BLOCKED with sticky_en=0: a non-stall cycle moves to IDLE and sets cnt to 0; a stall cycle holds BLOCKED.
REQ-020 BLOCKED with sticky_en=1: the state is held regardless of the bus until clear or reset.
REQ-021 cnt saturates at 2^CNT_W-1 and never wraps.
REQ-022 axis_block_sigs[i] = 1 exactly while the FSM of channel i is in BLOCKED; it is a registered state decode.
REQ-023 Latency: with T_eff = T, stall cycles at cycles 0..T-1 make axis_block_sigs[i] rise at cycle T; a non-stall cycle at cycle k in non-sticky BLOCKED makes the flag fall at cycle k+1.
REQ-024 any_block follows the same timing as axis_block_sigs.
REQ-025 A change to threshold while a channel is in STALL takes effect on the next comparison; if cnt already >= new T_eff, the next stall cycle moves the channel to BLOCKED.
REQ-026 First-block capture: when first_vld=0 and at least one channel enters BLOCKED in a cycle, first_ch is loaded with the index of the lowest such channel and first_vld is set, both on the same edge as the block flag.
REQ-027 Once first_vld=1, further block entries do not update first_ch.
REQ-028 clear has priority over all bus activity in its cycle: every FSM goes to IDLE, cnt goes to 0, first_vld goes to 0 and first_ch goes to 0 on the next edge; the bus is not sampled in that cycle.
REQ-029 Bits of first_ch above log2(NUM_CH) are driven 0.

Reset
REQ-030 ap_rst_n=0 sampled on a rising edge puts every FSM in IDLE, sets cnt to 0, axis_block_sigs to 0, any_block to 0, first_ch to 0 and first_vld to 0.
REQ-031 Reset asserted mid-stall or in BLOCKED discards all progress; after release, counting restarts from 0 on the first stall cycle.
REQ-032 Reset takes priority over clear.

Verification
REQ-033 threshold=4, sticky_en=0, ch0 stalled for cycles 0..5 then tready=1 at cycle 6 -> axis_block_sigs=2'b01 at cycles 4..6, 0 at cycle 7; first_ch=0 and first_vld=1 from cycle 4.
REQ-034 threshold=4, ch1 stalls 3 cycles, one handshake, then stalls 3 cycles -> axis_block_sigs stays 0 throughout.
REQ-035 threshold=0, ch1 single stall cycle at cycle 10 -> axis_block_sigs[1]=1 at cycle 11 only, first_ch=1.
REQ-036 threshold=2, ch0 and ch1 stalled from the same cycle 0 -> both flags rise at cycle 2, first_ch=0; sticky_en=1 with the stall removed -> flags stay 1 until a clear pulse at cycle 20, all outputs 0 at cycle 21.
REQ-037 threshold=3, ap_rst_n=0 at cycle 2 of a stall and released at cycle 3 with the stall continuing -> block flag rises at cycle 6, not cycle 3.
